// File: rtl/fp_pkg.sv
// Shared floating-point definitions for the multiplier/adder datapaths.
// Holds operand class encodings, rounding-mode constants, flag bit indices and
// helpers that derive format constants from the exponent/fraction widths.
package fp_pkg;

   typedef enum logic [1:0] {
      CLS_NORMAL = 2'b00,
      CLS_ZERO   = 2'b01,
      CLS_INF    = 2'b10,
      CLS_NAN    = 2'b11
   } fp_cls_e;

   localparam logic RND_TRUNC = 1'b0;
   localparam logic RND_RNE   = 1'b1;

   // Bit positions within the 4-bit flag vector {nan, overflow, underflow, inexact}
   localparam int unsigned FLG_NAN = 3;
   localparam int unsigned FLG_OVF = 2;
   localparam int unsigned FLG_UNF = 1;
   localparam int unsigned FLG_INX = 0;

   function automatic int unsigned fp_bias(int unsigned exp_w);
      return (32'd1 << (exp_w - 1)) - 32'd1;
   endfunction

   function automatic logic [63:0] fp_exp_ones(int unsigned exp_w);
      return (64'd1 << exp_w) - 64'd1;
   endfunction

   // Canonical quiet NaN, sign bit clear, right-aligned in a 64-bit word
   function automatic logic [63:0] fp_qnan(int unsigned exp_w, int unsigned man_w);
      return (fp_exp_ones(exp_w) << man_w) | (64'd1 << (man_w - 1));
   endfunction

endpackage

// File: rtl/fp_round.sv
// Combinational rounding of a normalised mantissa carrying guard and sticky bits.
// Ports:
//   rnd_mode  - 0 truncate, 1 round-to-nearest-even
//   exp_raw   - biased exponent, two's complement, EXP_W+2 bits
//   man_raw   - {hidden, fraction, guard, sticky}
//   exp_rnd   - exponent after carry renormalisation
//   frac_rnd  - rounded stored fraction
//   inexact   - any discarded bit was set
module fp_round
   import fp_pkg::*;
#(
   parameter int unsigned EXP_W = 8,
   parameter int unsigned MAN_W = 7
) (
   input  logic             rnd_mode,
   input  logic [EXP_W+1:0] exp_raw,
   input  logic [MAN_W+2:0] man_raw,
   output logic [EXP_W+1:0] exp_rnd,
   output logic [MAN_W-1:0] frac_rnd,
   output logic             inexact
);

   logic             guard;
   logic             sticky;
   logic             inc;
   logic [MAN_W+1:0] sum;

   assign guard   = man_raw[1];
   assign sticky  = man_raw[0];
   // Round up above half, or exactly at half when the kept LSB is odd
   assign inc     = (rnd_mode == RND_RNE) && guard && (sticky || man_raw[2]);
   assign sum     = {1'b0, man_raw[MAN_W+2:2]} + {{(MAN_W+1){1'b0}}, inc};
   assign inexact = guard | sticky;

   always_comb begin
      exp_rnd  = exp_raw;
      frac_rnd = sum[MAN_W-1:0];
      if (sum[MAN_W+1]) begin
         // Mantissa overflowed to 10.0...0: renormalise
         frac_rnd = sum[MAN_W:1];
         exp_rnd  = exp_raw + {{(EXP_W+1){1'b0}}, 1'b1};
      end
   end

endmodule

// File: rtl/fp_round_except_pipe.sv
// Two-stage round / exception / pack pipeline for the multiplier result.
// Stage 1 rounds the raw product, stage 2 resolves specials, overflow and
// flush-to-zero underflow and packs {sign, exponent, fraction}.
// Ports:
//   clk, rst_n              - clock, asynchronous active-low reset
//   in_valid/in_ready       - product handshake
//   in_sign/exp/man/cls     - raw product fields; rnd_mode sampled with in_valid
//   out_valid/out_ready     - result handshake
//   out_result, out_flags   - packed result and its {nan, ovf, unf, inx} flags
//   flags_clr, flags_sticky - software-clearable accumulated flags
module fp_round_except_pipe
   import fp_pkg::*;
#(
   parameter int unsigned EXP_W = 8,
   parameter int unsigned MAN_W = 7
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 in_sign,
   input  logic [EXP_W+1:0]     in_exp,
   input  logic [MAN_W+2:0]     in_man,
   input  logic [1:0]           in_cls,
   input  logic                 rnd_mode,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [EXP_W+MAN_W:0] out_result,
   output logic [3:0]           out_flags,
   input  logic                 flags_clr,
   output logic [3:0]           flags_sticky
);

   localparam int unsigned      RES_W    = 1 + EXP_W + MAN_W;
   localparam logic [EXP_W-1:0] EXP_ONES = EXP_W'(fp_exp_ones(EXP_W));
   localparam logic [RES_W-1:0] QNAN     = RES_W'(fp_qnan(EXP_W, MAN_W));

   logic             s1_load;
   logic             s2_load;
   logic             out_xfer;

   logic [EXP_W+1:0] rnd_exp;
   logic [MAN_W-1:0] rnd_frac;
   logic             rnd_inx;

   logic             s1_valid_q;
   logic             s1_sign_q;
   logic             s1_inx_q;
   fp_cls_e          s1_cls_q;
   logic [EXP_W+1:0] s1_exp_q;
   logic [MAN_W-1:0] s1_frac_q;

   logic             s2_valid_q;
   logic [RES_W-1:0] s2_result_q;
   logic [3:0]       s2_flags_q;
   logic [3:0]       sticky_q;

   logic             ovf;
   logic             unf;
   logic [RES_W-1:0] pack_result;
   logic [3:0]       pack_flags;

   // Each stage loads when empty or when its contents leave this cycle
   assign s2_load  = !s2_valid_q || out_ready;
   assign s1_load  = !s1_valid_q || s2_load;
   assign in_ready = s1_load;
   assign out_xfer = s2_valid_q && out_ready;

   fp_round #(
      .EXP_W (EXP_W),
      .MAN_W (MAN_W)
   ) u_round (
      .rnd_mode (rnd_mode),
      .exp_raw  (in_exp),
      .man_raw  (in_man),
      .exp_rnd  (rnd_exp),
      .frac_rnd (rnd_frac),
      .inexact  (rnd_inx)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_sign_q  <= 1'b0;
         s1_inx_q   <= 1'b0;
         s1_cls_q   <= CLS_NORMAL;
         s1_exp_q   <= '0;
         s1_frac_q  <= '0;
      end else if (s1_load) begin
         s1_valid_q <= in_valid;
         if (in_valid) begin
            s1_sign_q <= in_sign;
            s1_inx_q  <= rnd_inx;
            s1_cls_q  <= fp_cls_e'(in_cls);
            s1_exp_q  <= rnd_exp;
            s1_frac_q <= rnd_frac;
         end
      end
   end

   // Overflow: non-negative exponent at or above the all-ones code.
   // Underflow: negative or zero exponent; no subnormals, flush to zero.
   assign ovf = !s1_exp_q[EXP_W+1] && (s1_exp_q[EXP_W:0] >= {1'b0, EXP_ONES});
   assign unf = s1_exp_q[EXP_W+1] || (s1_exp_q == '0);

   always_comb begin
      pack_result          = {s1_sign_q, s1_exp_q[EXP_W-1:0], s1_frac_q};
      pack_flags           = '0;
      pack_flags[FLG_INX]  = s1_inx_q;
      unique case (s1_cls_q)
         CLS_NAN: begin
            pack_result         = QNAN;
            pack_flags          = '0;
            pack_flags[FLG_NAN] = 1'b1;
         end
         CLS_INF: begin
            pack_result = {s1_sign_q, EXP_ONES, {MAN_W{1'b0}}};
            pack_flags  = '0;
         end
         CLS_ZERO: begin
            pack_result = {s1_sign_q, {(EXP_W+MAN_W){1'b0}}};
            pack_flags  = '0;
         end
         CLS_NORMAL: begin
            if (ovf) begin
               pack_result         = {s1_sign_q, EXP_ONES, {MAN_W{1'b0}}};
               pack_flags[FLG_OVF] = 1'b1;
               pack_flags[FLG_INX] = 1'b1;
            end else if (unf) begin
               pack_result         = {s1_sign_q, {(EXP_W+MAN_W){1'b0}}};
               pack_flags[FLG_UNF] = 1'b1;
               pack_flags[FLG_INX] = 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid_q  <= 1'b0;
         s2_result_q <= '0;
         s2_flags_q  <= '0;
      end else if (s2_load) begin
         s2_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            s2_result_q <= pack_result;
            s2_flags_q  <= pack_flags;
         end
      end
   end

   // A clear coinciding with a transfer keeps the transferring result's flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sticky_q <= '0;
      end else if (out_xfer) begin
         sticky_q <= (flags_clr ? 4'b0000 : sticky_q) | s2_flags_q;
      end else if (flags_clr) begin
         sticky_q <= '0;
      end
   end

   assign out_valid    = s2_valid_q;
   assign out_result   = s2_result_q;
   assign out_flags    = s2_flags_q;
   assign flags_sticky = sticky_q;

endmodule

// File: tb/tb_fp_round_except_pipe.sv
// Self-checking bench: directed vectors, backpressure, reset mid-stream, a
// half-precision instance, then randomized traffic against an arithmetic model.
module tb_fp_round_except_pipe;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, in_sign, rnd_mode;
   logic [9:0]  in_exp, in_man;
   logic [1:0]  in_cls;
   logic        out_valid, out_ready, flags_clr;
   logic [15:0] out_result;
   logic [3:0]  out_flags, flags_sticky;

   logic        h_in_valid, h_in_ready, h_out_valid, h_out_ready, h_flags_clr;
   logic [6:0]  h_in_exp;
   logic [12:0] h_in_man;
   logic [15:0] h_out_result;
   logic [3:0]  h_out_flags, h_flags_sticky;

   int          n_chk = 0;
   int          n_fail = 0;
   bit          mon_en = 1'b0;
   logic [19:0] sb_q[$];
   logic [19:0] head;
   logic [3:0]  m_sticky;
   bit          xfer;

   always #5 clk = ~clk;

   fp_round_except_pipe dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_sign      (in_sign),
      .in_exp       (in_exp),
      .in_man       (in_man),
      .in_cls       (in_cls),
      .rnd_mode     (rnd_mode),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_result   (out_result),
      .out_flags    (out_flags),
      .flags_clr    (flags_clr),
      .flags_sticky (flags_sticky)
   );

   fp_round_except_pipe #(
      .EXP_W (5),
      .MAN_W (10)
   ) dut_half (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (h_in_valid),
      .in_ready     (h_in_ready),
      .in_sign      (1'b0),
      .in_exp       (h_in_exp),
      .in_man       (h_in_man),
      .in_cls       (2'b00),
      .rnd_mode     (1'b1),
      .out_valid    (h_out_valid),
      .out_ready    (h_out_ready),
      .out_result   (h_out_result),
      .out_flags    (h_out_flags),
      .flags_clr    (h_flags_clr),
      .flags_sticky (h_flags_sticky)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // bfloat16 reference: returns {flags[3:0], result[15:0]}
   function automatic logic [19:0] ref_model(bit s, logic [9:0] e_raw, logic [9:0] m,
                                             logic [1:0] c, bit r);
      int e;
      int sig;
      bit g, st;
      if (c == 2'b11) return {4'b1000, 16'h7FC0};
      if (c == 2'b10) return {4'b0000, s, 15'h7F80};
      if (c == 2'b01) return {4'b0000, s, 15'h0000};
      e   = e_raw[9] ? int'(e_raw) - 1024 : int'(e_raw);
      sig = int'(m) / 4;
      g   = m[1];
      st  = m[0];
      if (r && g && (st || (sig % 2 == 1))) sig = sig + 1;
      if (sig >= 256) begin
         sig = sig / 2;
         e   = e + 1;
         if (e == 512) e = -512;
      end
      if (e >= 255) return {4'b0101, s, 15'h7F80};
      if (e <= 0)   return {4'b0011, s, 15'h0000};
      return {3'b000, g | st, s, e[7:0], sig[6:0]};
   endfunction

   // Scoreboard monitor for the randomized phase
   always @(negedge clk) begin
      if (mon_en) begin
         check_eq("sticky", 32'(flags_sticky), 32'(m_sticky));
         check_eq("in_ready", 32'(in_ready), 32'((sb_q.size() < 2) || out_ready));
         check_eq("out_valid_empty_q", 32'(out_valid && (sb_q.size() == 0)), 32'd0);
         xfer = 1'b0;
         if (out_valid && sb_q.size() != 0) begin
            head = sb_q[0];
            check_eq("rand_result", 32'(out_result), 32'(head[15:0]));
            check_eq("rand_flags", 32'(out_flags), 32'(head[19:16]));
            if (out_ready) begin
               xfer = 1'b1;
               void'(sb_q.pop_front());
               m_sticky = (flags_clr ? 4'b0000 : m_sticky) | head[19:16];
            end
         end
         if (!xfer && flags_clr) m_sticky = 4'b0000;
         if (in_valid && in_ready)
            sb_q.push_back(ref_model(in_sign, in_exp, in_man, in_cls, rnd_mode));
      end
   end

   task automatic drive(bit s, logic [9:0] e, logic [9:0] m, logic [1:0] c, bit r);
      in_sign  = s;
      in_exp   = e;
      in_man   = m;
      in_cls   = c;
      rnd_mode = r;
   endtask

   // One isolated transfer into an empty pipe with out_ready high
   task automatic run_vec(input string tag, input bit s, input logic [9:0] e,
                          input logic [9:0] m, input logic [1:0] c, input bit r,
                          input logic [15:0] er, input logic [3:0] ef);
      drive(s, e, m, c, r);
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check_eq({tag, "_early"}, 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      check_eq({tag, "_valid"}, 32'(out_valid), 32'd1);
      check_eq({tag, "_res"}, 32'(out_result), 32'(er));
      check_eq({tag, "_flg"}, 32'(out_flags), 32'(ef));
      @(posedge clk); #1;
   endtask

   function automatic logic [9:0] rand_exp();
      case ($urandom_range(0, 3))
         0:       return 10'($urandom);
         1:       return 10'($urandom_range(0, 4)) - 10'd2;
         2:       return 10'($urandom_range(250, 258));
         default: return 10'($urandom_range(100, 150));
      endcase
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [9:0]  bp_e[4]   = '{10'd254, 10'd127, 10'd0, 10'd127};
      logic [9:0]  bp_m[4]   = '{10'h3FF, 10'h200, 10'h200, 10'h3FF};
      logic [1:0]  bp_c[4]   = '{2'b00, 2'b11, 2'b00, 2'b00};
      bit          bp_r[4]   = '{1'b1, 1'b1, 1'b1, 1'b0};
      logic [15:0] bp_res[4] = '{16'h7F80, 16'h7FC0, 16'h0000, 16'h3FFF};
      logic [3:0]  bp_flg[4] = '{4'h5, 4'h8, 4'h3, 4'h1};
      int acc, outs;

      rst_n = 1'b0;
      in_valid = 1'b0; out_ready = 1'b1; flags_clr = 1'b0;
      drive(1'b0, 10'd0, 10'd0, 2'b00, 1'b0);
      h_in_valid = 1'b0; h_out_ready = 1'b1; h_flags_clr = 1'b0;
      h_in_exp = '0; h_in_man = '0;
      #1;
      check_eq("rst_in_ready", 32'(in_ready), 32'd1);
      check_eq("rst_out_valid", 32'(out_valid), 32'd0);
      check_eq("rst_result", 32'(out_result), 32'd0);
      check_eq("rst_sticky", 32'(flags_sticky), 32'd0);
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      run_vec("basic",     1'b0, 10'd127,   10'h200, 2'b00, 1'b1, 16'h3F80, 4'h0);
      run_vec("carry_rne", 1'b0, 10'd127,   10'h3FF, 2'b00, 1'b1, 16'h4000, 4'h1);
      run_vec("carry_trc", 1'b0, 10'd127,   10'h3FF, 2'b00, 1'b0, 16'h3FFF, 4'h1);
      run_vec("tie_even",  1'b0, 10'd127,   10'h202, 2'b00, 1'b1, 16'h3F80, 4'h1);
      run_vec("tie_odd",   1'b0, 10'd127,   10'h206, 2'b00, 1'b1, 16'h3F82, 4'h1);
      run_vec("ovf",       1'b0, 10'd254,   10'h3FF, 2'b00, 1'b1, 16'h7F80, 4'h5);
      run_vec("unf_neg",   1'b1, 10'h3FE,   10'h200, 2'b00, 1'b1, 16'h8000, 4'h3);
      run_vec("unf_zero",  1'b0, 10'd0,     10'h200, 2'b00, 1'b1, 16'h0000, 4'h3);
      run_vec("nan",       1'b1, 10'd5,     10'h155, 2'b11, 1'b1, 16'h7FC0, 4'h8);
      run_vec("inf",       1'b1, 10'd5,     10'h155, 2'b10, 1'b1, 16'hFF80, 4'h0);
      run_vec("zero_neg",  1'b1, 10'd127,   10'h3FF, 2'b01, 1'b1, 16'h8000, 4'h0);
      run_vec("zero_pos",  1'b0, 10'd127,   10'h3FF, 2'b01, 1'b1, 16'h0000, 4'h0);

      // Backpressure: four offers, consumer stalled for five cycles
      flags_clr = 1'b1;
      @(posedge clk); #1;
      flags_clr = 1'b0;
      check_eq("clr_sticky", 32'(flags_sticky), 32'd0);
      acc = 0;
      outs = 0;
      for (int cyc = 0; cyc < 14; cyc++) begin
         out_ready = (cyc >= 5);
         in_valid  = (acc < 4);
         if (acc < 4) drive(1'b0, bp_e[acc], bp_m[acc], bp_c[acc], bp_r[acc]);
         flags_clr = (outs == 3);
         @(negedge clk);
         check_eq("bp_in_ready", 32'(in_ready), 32'(((acc - outs) < 2) || out_ready));
         if (outs == 3 && out_valid && out_ready)
            check_eq("bp_sticky_or", 32'(flags_sticky), 32'hF);
         if (out_valid && outs < 4) begin
            check_eq("bp_res", 32'(out_result), 32'(bp_res[outs]));
            check_eq("bp_flg", 32'(out_flags), 32'(bp_flg[outs]));
            if (out_ready) outs++;
         end
         if (in_valid && in_ready) acc++;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      flags_clr = 1'b0;
      check_eq("bp_count", 32'(outs), 32'd4);
      check_eq("bp_sticky_last", 32'(flags_sticky), 32'h1);

      // Reset with both stages full
      out_ready = 1'b0;
      in_valid = 1'b1;
      drive(1'b0, bp_e[0], bp_m[0], bp_c[0], bp_r[0]);
      @(posedge clk); #1;
      drive(1'b0, bp_e[1], bp_m[1], bp_c[1], bp_r[1]);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check_eq("full_out_valid", 32'(out_valid), 32'd1);
      check_eq("full_in_ready", 32'(in_ready), 32'd0);
      #2 rst_n = 1'b0;
      #1;
      check_eq("mid_rst_out_valid", 32'(out_valid), 32'd0);
      check_eq("mid_rst_sticky", 32'(flags_sticky), 32'd0);
      check_eq("mid_rst_result", 32'(out_result), 32'd0);
      check_eq("mid_rst_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      check_eq("post_rst_out_valid", 32'(out_valid), 32'd0);

      // Half precision instance
      h_in_exp = 7'd15;
      h_in_man = 13'h1000;
      h_in_valid = 1'b1;
      @(posedge clk); #1;
      h_in_valid = 1'b0;
      @(posedge clk); #1;
      check_eq("half_valid", 32'(h_out_valid), 32'd1);
      check_eq("half_res", 32'(h_out_result), 32'h3C00);
      check_eq("half_flg", 32'(h_out_flags), 32'd0);

      // Randomized traffic
      m_sticky = 4'b0000;
      mon_en = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         in_valid  = ($urandom_range(0, 9) < 7);
         drive(1'($urandom_range(0, 1)), rand_exp(), 10'($urandom),
               ($urandom_range(0, 7) < 5) ? 2'b00 : 2'($urandom_range(1, 3)),
               1'($urandom_range(0, 1)));
         out_ready = ($urandom_range(0, 9) < 7);
         flags_clr = ($urandom_range(0, 19) == 0);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      flags_clr = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check_eq("drain_empty", 32'(sb_q.size()), 32'd0);
      mon_en = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/fp_round_except_pipe.md
# fp_round_except_pipe

Parametrised, pipelined round-and-exception stage for the approximate floating-point multiplier datapath.
- Takes the raw product (sign, extended biased exponent, normalised mantissa with guard/sticky, operand class) from the multiplier core.
- Applies a selectable rounding mode, then resolves overflow, underflow, zero, infinity and NaN.
- Packs an IEEE-style result of any exponent/mantissa width; bfloat16 is the default.
- Adds a valid/ready handshake, per-result exception flags and software-clearable sticky flags. The previous purely combinational, bfloat16-only, truncating packer had none of these.

## Interface
- EXP_W, 8, result exponent width; bias = 2^(EXP_W-1)-1
- MAN_W, 7, stored fraction width; result width = 1+EXP_W+MAN_W

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  product available
- in_ready  out  1  stage can accept
- in_sign  in  1  product sign
- in_exp  in  EXP_W+2  biased exponent, two's complement; MSB set = negative
- in_man  in  MAN_W+3  [MAN_W+2] hidden bit, [MAN_W+1:2] fraction, [1] guard, [0] sticky
- in_cls  in  2  operand class: 00 normal, 01 zero, 10 infinity, 11 NaN
- rnd_mode  in  1  0 truncate, 1 round-to-nearest-even; sampled with in_valid
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts
- out_result  out  1+EXP_W+MAN_W  {sign, exponent, fraction}
- out_flags  out  4  {nan, overflow, underflow, inexact} for out_result
- flags_clr  in  1  clear sticky flags
- flags_sticky  out  4  OR of out_flags over all accepted results since reset/clear

## Operation
- Stage 1, round (normal class only):
  - inc = rnd_mode & guard & (sticky | fraction LSB).
  - {hidden,fraction} + inc is computed at MAN_W+2 bits.
  - On carry out, the mantissa shifts right by 1 and the exponent is incremented at EXP_W+2 bits.
  - inexact = guard | sticky.
- Stage 2, except/pack, in priority order:
  - NaN class → {0, all-ones, 1 followed by zeros} (canonical quiet NaN, sign forced 0); flags nan only.
  - Infinity class → {sign, all-ones, 0}; no flags.
  - Zero class → {sign, 0, 0}; no flags.
  - Rounded exponent non-negative and ≥ 2^EXP_W-1 → {sign, all-ones, 0}; overflow=1, inexact=1.
  - Rounded exponent negative or zero → {sign, 0, 0}. No subnormals; flush to zero. underflow=1, inexact=1.
  - Otherwise → {sign, exp[EXP_W-1:0], rounded fraction}; inexact from stage 1.
- Sticky flags:
  - On each out_valid & out_ready: flags_sticky ← (flags_clr ? 0 : flags_sticky) | out_flags.
  - flags_clr with no transfer clears the sticky flags.
  - When clear and transfer coincide, the new flags survive.

## Timing
- Latency: 2 cycles from an in_valid & in_ready transfer to out_valid.
- Throughput: 1 result per cycle while out_ready stays high.
- Each stage holds a valid bit plus registered data. Each stage loads when it is empty or its contents are leaving this cycle.
- in_ready = !s1_valid | (!s2_valid | out_ready). This is combinational from out_ready; there is no skid buffer.
- Under backpressure:
  - Up to 2 results are held.
  - Payload and out_valid stay stable while out_valid & !out_ready.
  - Nothing is dropped or duplicated.
- Reset, asynchronous, also valid mid-operation:
  - s1_valid, s2_valid, out_valid, in_ready-internal state, out_result, out_flags and flags_sticky all go to 0.
  - In-flight results are discarded.
  - in_ready is 1 after reset.

## Structure
- Shared package fp_pkg holds:
  - class encodings CLS_NORMAL/ZERO/INF/NAN
  - rounding-mode constants RND_TRUNC/RND_RNE
  - flag bit indices FLG_NAN/OVF/UNF/INX
  - functions for bias, all-ones exponent and canonical NaN from EXP_W/MAN_W
- One sub-module, fp_round (stage-1 combinational rounding: mantissa increment, carry renormalise, exponent adjust, inexact). It is reused by the planned adder path.
- Pipeline registers and handshake stay in the top.

## Test plan
Default parameters (bfloat16) unless stated.
- Basic pack: exp 127, man 0x200, cls normal, RNE → 0x3F80 after 2 cycles; flags 0000.
- Rounding carry:
  - exp 127, man 0x3FF, RNE → 0x4000, flags 0001.
  - Same input with truncate → 0x3FFF, flags 0001.
- Overflow and underflow:
  - exp 254, man 0x3FF, RNE → 0x7F80, flags 0101.
  - exp 10'h3FE (-2), sign 1 → 0x8000, flags 0011.
  - exp 0 → 0x0000 underflow.
- Specials:
  - cls NaN, sign 1 → 0x7FC0, flags 1000.
  - cls inf, sign 1 → 0xFF80.
  - cls zero → signed zero; all with flags 0000.
- Backpressure:
  - Drive 4 back-to-back inputs with out_ready low for 5 cycles. in_ready must drop after 2 are accepted.
  - Outputs then emerge in order, unchanged, with no loss.
  - Sticky flags equal the OR of all four results' flags.
  - flags_clr pulsed on the last transfer leaves only the last flags set.
- Reset mid-stream: assert rst_n low with both stages full → out_valid 0 and flags_sticky 0 immediately. With EXP_W=5, MAN_W=10, exp 15, man 0x1000 → 0x3C00.
